// File: rtl/branch_update_ctrl_pkg.sv
// Shared types and defaults for the branch update controller.
// Holds the core XLEN and the update-queue / squash-window defaults.
package branch_update_ctrl_pkg;

    localparam int XLEN              = 32;
    localparam int UPDQ_DEPTH        = 4;
    localparam int SQUASH_CYCLES_DEF = 2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
    } upd_entry_t;

endpackage

// File: rtl/branch_update_ctrl_fifo.sv
// Small synchronous FIFO for predictor update entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// Trains the direction predictor from resolved branches and issues fetch redirects.
// A mispredict redirects once, then ignores wrong-path resolves for a fixed window.
module branch_update_ctrl
    import branch_update_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH   = UPDQ_DEPTH,
    parameter int SQUASH_CYCLES = SQUASH_CYCLES_DEF,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 resolve_valid,
    input  logic                 resolve_is_branch,
    input  logic [XLEN-1:0]      resolve_pc,
    input  logic                 resolve_taken,
    input  logic [XLEN-1:0]      resolve_target,
    input  logic                 resolve_pred_taken,
    output logic                 resolve_ready,
    input  logic                 pipe_flush,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    input  logic                 upd_ready,
    output logic                 upd_enable,
    output logic                 upd_is_branch,
    output logic [XLEN-1:0]      upd_pc,
    output logic                 upd_taken,
    output logic                 queue_empty,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count,
    output ctrl_state_e          state_dbg
);
    localparam int                   SQW     = $clog2(SQUASH_CYCLES + 1);
    localparam logic [SQW-1:0]       SQ_LOAD = SQW'(SQUASH_CYCLES);
    localparam logic [SQW-1:0]       SQ_ONE  = SQW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    ctrl_state_e     state;
    logic [SQW-1:0]  sq_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            mispredict;
    logic            pop;
    upd_entry_t      push_entry;
    upd_entry_t      head_entry;

    // Valid/ready: a branch transfers on a cycle where resolve_valid && resolve_ready,
    // unless pipe_flush kills it; non-branch resolves are simply ignored.
    assign resolve_ready = (state == ST_RUN) && !fifo_full;
    assign accept        = resolve_ready && resolve_valid && resolve_is_branch && !pipe_flush;
    assign mispredict    = resolve_taken != resolve_pred_taken;
    assign pop           = !fifo_empty && upd_ready;
    assign queue_empty   = fifo_empty;
    assign state_dbg     = state;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = resolve_pc;
        push_entry.taken = resolve_taken;
    end

    sync_fifo #(
        .WIDTH($bits(upd_entry_t)),
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            sq_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && mispredict) begin
                        state  <= ST_SQUASH;
                        sq_cnt <= SQ_LOAD;
                    end
                end
                ST_SQUASH: begin
                    if (pipe_flush || sq_cnt <= SQ_ONE) begin
                        state  <= ST_RUN;
                        sq_cnt <= '0;
                    end else begin
                        sq_cnt <= sq_cnt - SQ_ONE;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    sq_cnt <= '0;
                end
            endcase
        end
    end

    // A flush in the same cycle already blocks accept, so it also blocks the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept && mispredict;
            if (accept && mispredict)
                redirect_pc <= resolve_taken ? resolve_target : resolve_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (accept) begin
            if (~&branch_count) branch_count <= branch_count + CNT_ONE;
            if (mispredict && ~&mispredict_count)
                mispredict_count <= mispredict_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_enable    <= 1'b0;
            upd_is_branch <= 1'b0;
            upd_pc        <= '0;
            upd_taken     <= 1'b0;
        end else begin
            upd_enable    <= pop;
            upd_is_branch <= pop;
            if (pop) begin
                upd_pc    <= head_entry.pc;
                upd_taken <= head_entry.taken;
            end
        end
    end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed bench for branch_update_ctrl: expected updates and redirects are queued
// when stimulus is driven and compared whenever the DUT emits them.
module tb_branch_update_ctrl;
    import branch_update_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              resolve_valid, resolve_is_branch, resolve_taken, resolve_pred_taken;
    logic [XLEN-1:0]   resolve_pc, resolve_target;
    logic              resolve_ready, pipe_flush, redirect_valid, upd_ready;
    logic [XLEN-1:0]   redirect_pc, upd_pc;
    logic              upd_enable, upd_is_branch, upd_taken, queue_empty;
    logic [31:0]       branch_count, mispredict_count;
    ctrl_state_e       state_dbg;

    logic [XLEN:0]     exp_q[$];
    logic [XLEN-1:0]   redir_q[$];
    int                total = 0;
    int                bad = 0;
    int                exp_br = 0;
    int                exp_mis = 0;

    branch_update_ctrl dut (
        .clk(clk), .reset(reset),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
        .resolve_ready(resolve_ready), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_ready(upd_ready), .upd_enable(upd_enable), .upd_is_branch(upd_is_branch),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .queue_empty(queue_empty),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; inputs are sampled by the following posedge.
    task automatic send(input logic [XLEN-1:0] pc, input logic taken, input logic pred,
                        input logic [XLEN-1:0] tgt, input logic is_br, input logic flush,
                        input logic exp_acc);
        resolve_valid      = 1'b1;
        resolve_is_branch  = is_br;
        resolve_pc         = pc;
        resolve_taken      = taken;
        resolve_pred_taken = pred;
        resolve_target     = tgt;
        pipe_flush         = flush;
        if (exp_acc) begin
            exp_q.push_back({pc, taken});
            exp_br++;
            if (taken != pred) begin
                redir_q.push_back(taken ? tgt : pc + 32'd4);
                exp_mis++;
            end
        end
        @(negedge clk);
        resolve_valid = 1'b0;
        pipe_flush    = 1'b0;
    endtask

    task automatic flush_only();
        pipe_flush = 1'b1;
        @(negedge clk);
        pipe_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (upd_enable) begin
                if (exp_q.size() == 0) check("upd_unexpected", upd_enable, 1'b0);
                else begin
                    logic [XLEN:0] e;
                    e = exp_q.pop_front();
                    check("upd_pc", upd_pc, e[XLEN:1]);
                    check("upd_taken", upd_taken, e[0]);
                    check("upd_is_branch", upd_is_branch, 1'b1);
                end
            end else begin
                check("upd_is_branch_idle", upd_is_branch, 1'b0);
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) check("redirect_unexpected", redirect_valid, 1'b0);
                else check("redirect_pc", redirect_pc, redir_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; resolve_valid = 1'b0; resolve_is_branch = 1'b0; resolve_pc = '0;
        resolve_taken = 1'b0; resolve_target = '0; resolve_pred_taken = 1'b0;
        pipe_flush = 1'b0; upd_ready = 1'b1;
        #12;
        check("rst_resolve_ready", resolve_ready, 1'b1);
        check("rst_queue_empty", queue_empty, 1'b1);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_upd_enable", upd_enable, 1'b0);
        check("rst_branch_count", branch_count, 32'h0);
        check("rst_state", state_dbg, ST_RUN);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Correctly predicted branch trains the predictor, no redirect.
        send(32'h100, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        check("t1_redirect_valid", redirect_valid, 1'b0);
        check("t1_branch_count", branch_count, exp_br);
        idle(3);
        check("t1_queue_empty", queue_empty, 1'b1);

        // Taken mispredict: redirect to target, two wrong-path resolves ignored.
        send(32'h200, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b1);
        check("t2_redirect_valid", redirect_valid, 1'b1);
        check("t2_state_squash", state_dbg, ST_SQUASH);
        send(32'h210, 1'b1, 1'b0, 32'h90, 1'b1, 1'b0, 1'b0);
        send(32'h220, 1'b0, 1'b1, 32'h90, 1'b1, 1'b0, 1'b0);
        check("t2_state_run", state_dbg, ST_RUN);
        check("t2_branch_count", branch_count, exp_br);
        check("t2_mispredict_count", mispredict_count, exp_mis);
        send(32'h230, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        send(32'h240, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t2_nonbranch_count", branch_count, exp_br);
        idle(3);

        // Not-taken mispredicts, including fall-through wrap.
        send(32'h300, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b1);
        idle(3);
        send(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("t3_mispredict_count", mispredict_count, exp_mis);

        // Fill the queue with the update port stalled.
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            send(32'h400 + 32'(i * 4), t, t, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        check("t4_resolve_ready_full", resolve_ready, 1'b0);
        check("t4_queue_empty_full", queue_empty, 1'b0);
        send(32'h500, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        check("t4_branch_count_drop", branch_count, exp_br);
        upd_ready = 1'b1;
        idle(6);
        check("t4_queue_drained", queue_empty, 1'b1);
        check("t4_resolve_ready", resolve_ready, 1'b1);

        // Flush kills a same-cycle mispredict; flush during squash reopens immediately.
        send(32'h600, 1'b1, 1'b0, 32'h90, 1'b1, 1'b1, 1'b0);
        check("t5_state_after_flush", state_dbg, ST_RUN);
        check("t5_branch_count", branch_count, exp_br);
        check("t5_queue_empty", queue_empty, 1'b1);
        send(32'h700, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        flush_only();
        check("t5_state_flushed", state_dbg, ST_RUN);
        send(32'h710, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        check("t5_accept_after_flush", branch_count, exp_br);
        idle(4);

        // Reset with queued entries and a redirect in flight.
        upd_ready = 1'b0;
        send(32'h800, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        send(32'h804, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        send(32'h808, 1'b1, 1'b0, 32'hA0, 1'b1, 1'b0, 1'b1);
        check("t6_redirect_pending", redirect_valid, 1'b1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        redir_q.delete();
        exp_br = 0;
        exp_mis = 0;
        #1;
        check("t6_redirect_valid", redirect_valid, 1'b0);
        check("t6_redirect_pc", redirect_pc, 32'h0);
        check("t6_queue_empty", queue_empty, 1'b1);
        check("t6_resolve_ready", resolve_ready, 1'b1);
        check("t6_branch_count", branch_count, 32'h0);
        check("t6_mispredict_count", mispredict_count, 32'h0);
        check("t6_state", state_dbg, ST_RUN);
        idle(2);
        reset = 1'b0;
        upd_ready = 1'b1;
        idle(6);
        check("t6_queue_empty_after", queue_empty, 1'b1);

        check("end_upd_left", 32'(exp_q.size()), 32'h0);
        check("end_redirect_left", 32'(redir_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_update_ctrl.md
Name: branch_update_ctrl

Overview:
Sequences training of the 2-bit direction predictor and generates fetch redirects. Accepts resolved branches from EX and detects direction mispredicts. Issues a registered redirect and squashes wrong-path resolves for a programmable window. Buffers predictor updates in a small FIFO and drains them one per cycle into the predictor update port (update_enable / pc_update / branch_taken / is_branch).

Parameters:
QUEUE_DEPTH, 4, update FIFO entries; power of two, minimum 2
SQUASH_CYCLES, 2, cycles after a redirect during which resolve inputs are ignored; minimum 1
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
resolve_valid  input  1  EX presents a resolved instruction
resolve_is_branch  input  1  instruction is a conditional branch
resolve_pc  input  `XLEN  PC of the resolved instruction
resolve_taken  input  1  actual direction
resolve_target  input  `XLEN  computed taken target
resolve_pred_taken  input  1  direction predicted at IF
resolve_ready  output  1  controller can accept a branch this cycle
pipe_flush  input  1  trap/exception flush; has priority over everything
redirect_valid  output  1  one-cycle pulse: fetch must restart at redirect_pc
redirect_pc  output  `XLEN  corrected fetch PC
upd_ready  input  1  predictor update port free this cycle
upd_enable  output  1  drives predictor update_enable
upd_is_branch  output  1  drives predictor is_branch
upd_pc  output  `XLEN  drives predictor pc_update
upd_taken  output  1  drives predictor branch_taken
queue_empty  output  1  FIFO empty
branch_count  output  CNT_WIDTH  accepted branches, saturating
mispredict_count  output  CNT_WIDTH  mispredicts, saturating

Behaviour:
- Reset values: all outputs 0 except queue_empty=1 and resolve_ready=1. FIFO pointers and counters 0. State RUN.
- States:
  - RUN: resolves are accepted.
  - SQUASH: a down-counter loaded with SQUASH_CYCLES. resolve_valid is ignored: no enqueue, no redirect, no count. Decrement each cycle; go to RUN when it reaches 0.
- Accept condition: state==RUN && resolve_valid && resolve_is_branch && !full && !pipe_flush.
- resolve_ready = (state==RUN) && !full, combinational.
- Non-branch resolves never enqueue, redirect or count.
- On accept:
  - Push {resolve_pc, resolve_taken} into the FIFO.
  - branch_count += 1, saturating at all-ones.
- Mispredict is defined as resolve_taken != resolve_pred_taken. On an accepted mispredict:
  - Next cycle: redirect_valid=1 and redirect_pc = resolve_taken ? resolve_target : resolve_pc+4 (mod 2^XLEN).
  - mispredict_count += 1, saturating.
  - State goes to SQUASH.
- redirect_valid is a single-cycle pulse; redirect_pc holds its last value when redirect_valid is low.
- Drain: when the FIFO is non-empty and upd_ready=1, the head is popped. Next cycle: upd_enable=1, upd_is_branch=1, upd_pc and upd_taken carry the popped entry (registered outputs, 1-cycle latency). Otherwise upd_enable=0 and upd_is_branch=0.
- Throughput: at most one push and one pop per cycle.
  - A simultaneous push and pop with the FIFO non-full keeps occupancy unchanged.
  - When full, no push occurs even if a pop happens the same cycle.
- Ordering: updates leave the FIFO in acceptance order. Wrap-around uses pointers one bit wider than log2(QUEUE_DEPTH); full is detected when the MSBs differ and the rest are equal.
- pipe_flush:
  - Kills the resolve presented in the same cycle: no push and no redirect.
  - Cancels a pending SQUASH and returns the state to RUN.
  - Suppresses any redirect_valid pulse scheduled for the next cycle.
  - Does NOT empty the FIFO: queued entries came from architecturally resolved branches and still train the predictor.
- Reset mid-operation: the FIFO contents are discarded and any in-flight update or redirect pulse is dropped asynchronously.

Decomposition:
- isa.v gains `UPDQ_DEPTH (default for QUEUE_DEPTH) and `SQUASH_CYCLES. XLEN comes from the existing `XLEN.
- Sub-module sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty) holds the {pc, taken} entries.
- The FSM, redirect logic and counters live in branch_update_ctrl.

Test Plan:
- Reset, then resolve pc=0x100, taken=1, pred=1 -> no redirect; branch_count=1; one cycle after a pop, upd_enable=1, upd_pc=0x100, upd_taken=1.
- Mispredict pc=0x200, taken=1, pred=0, target=0x80 -> next cycle redirect_valid=1, redirect_pc=0x80; next two resolve_valid cycles ignored; mispredict_count=1.
- Mispredict pc=0x300, taken=0, pred=1 -> redirect_pc=0x304. pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x0.
- Hold upd_ready=0 and push 4 branches -> resolve_ready=0 and a 5th resolve is dropped. Release upd_ready -> four updates drain in order over 4 cycles, then queue_empty=1.
- Mispredict asserted together with pipe_flush -> no redirect, no enqueue, state stays RUN. A flush during SQUASH -> the next resolve is accepted immediately.
- Assert reset with 3 queued entries and a redirect pending -> all outputs return to reset values; no upd_enable pulse after reset release.
